// File: rtl/cfs_rx_ctrl.sv
// Receive-side controller in front of the aligner RX FIFO: checks each MD RX
// offset/size pair, pushes legal transfers as {size, offset, data}, and answers illegal ones with an error.
module cfs_rx_ctrl #(
  parameter  int ALGN_DATA_WIDTH = 32,
  localparam int BYTES           = ALGN_DATA_WIDTH / 8,
  localparam int OFFSET_WIDTH    = (ALGN_DATA_WIDTH == 8) ? 1 : $clog2(BYTES),
  localparam int SIZE_WIDTH      = $clog2(BYTES) + 1,
  localparam int PUSH_WIDTH      = ALGN_DATA_WIDTH + OFFSET_WIDTH + SIZE_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
  input  logic [OFFSET_WIDTH-1:0]    md_rx_offset,
  input  logic [SIZE_WIDTH-1:0]      md_rx_size,
  output logic                       md_rx_ready,
  output logic                       md_rx_err,
  output logic                       push_valid,
  output logic [PUSH_WIDTH-1:0]      push_data,
  input  logic                       push_ready,
  input  logic                       drop_cnt_clr,
  output logic [7:0]                 drop_cnt,
  output logic                       drop_max
);

  typedef enum logic [1:0] {
    IDLE,
    PUSH,
    RESP
  } state_e;

  // One extra bit so offset + size and BYTES + offset cannot wrap.
  localparam int CHK_WIDTH = SIZE_WIDTH + 1;

  state_e                  state_q, state_d;
  logic                    push_valid_q, push_valid_d;
  logic [PUSH_WIDTH-1:0]   push_data_q, push_data_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
  logic                    drop_max_q, drop_max_d;

  logic [CHK_WIDTH-1:0]    off_ext, size_ext, bytes_ext, span, mod_base, divisor;
  logic                    is_legal;
  logic                    drop_inc;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    off_ext   = CHK_WIDTH'(md_rx_offset);
    size_ext  = CHK_WIDTH'(md_rx_size);
    bytes_ext = CHK_WIDTH'(BYTES);
    span      = off_ext + size_ext;
    mod_base  = bytes_ext + off_ext;
    divisor   = (size_ext == '0) ? CHK_WIDTH'(1) : size_ext;
    is_legal  = (size_ext != '0) && (span <= bytes_ext) && ((mod_base % divisor) == '0);
  end

  assign drop_inc = (state_q == IDLE) && md_rx_valid && !is_legal;

  always_comb begin
    state_d      = state_q;
    push_valid_d = push_valid_q;
    push_data_d  = push_data_q;
    ready_d      = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (md_rx_valid) begin
          if (is_legal) begin
            push_data_d  = {md_rx_size, md_rx_offset, md_rx_data};
            push_valid_d = 1'b1;
            state_d      = PUSH;
          end else begin
            // Response is registered here so it appears in the very next cycle.
            ready_d = 1'b1;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      PUSH: begin
        if (push_valid_q && push_ready) begin
          push_valid_d = 1'b0;
          ready_d      = 1'b1;
          err_d        = 1'b0;
          state_d      = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    drop_max_d = 1'b0;
    if (drop_cnt_clr) begin
      drop_cnt_d = drop_inc ? 8'd1 : 8'd0;
    end else if (drop_inc && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
      drop_max_d = (drop_cnt_q == 8'hFE);
    end
  end

  // NOTE: sequential state uses non-blocking '<='; push_data is a plain
  // register (not a memory), so it is reset along with every other output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      drop_cnt_q   <= 8'd0;
      drop_max_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_max_q   <= drop_max_d;
    end
  end

  assign md_rx_ready = ready_q;
  assign md_rx_err   = err_q;
  assign push_valid  = push_valid_q;
  assign push_data   = push_data_q;
  assign drop_cnt    = drop_cnt_q;
  assign drop_max    = drop_max_q;

endmodule

// File: tb/tb_cfs_rx_ctrl.sv
// Directed bench for cfs_rx_ctrl at ALGN_DATA_WIDTH=32: legality, FIFO stall,
// drop counter saturation/clear and mid-transfer reset.
module tb_cfs_rx_ctrl;

  localparam int DW = 32;
  localparam int OW = 2;
  localparam int SW = 3;
  localparam int PW = DW + OW + SW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          md_rx_valid = 1'b0;
  logic [DW-1:0] md_rx_data = '0;
  logic [OW-1:0] md_rx_offset = '0;
  logic [SW-1:0] md_rx_size = '0;
  logic          md_rx_ready;
  logic          md_rx_err;
  logic          push_valid;
  logic [PW-1:0] push_data;
  logic          push_ready;
  logic          drop_cnt_clr = 1'b0;
  logic [7:0]    drop_cnt;
  logic          drop_max;
  logic          fifo_full = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [PW-1:0] pushed_q[$];

  always #5 clk = ~clk;

  // FIFO model: accept is combinational from push_valid and !full.
  assign push_ready = push_valid & ~fifo_full;

  always @(posedge clk) begin
    if (reset_n && push_valid && push_ready) pushed_q.push_back(push_data);
  end

  cfs_rx_ctrl #(.ALGN_DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .md_rx_valid  (md_rx_valid),
    .md_rx_data   (md_rx_data),
    .md_rx_offset (md_rx_offset),
    .md_rx_size   (md_rx_size),
    .md_rx_ready  (md_rx_ready),
    .md_rx_err    (md_rx_err),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .drop_cnt_clr (drop_cnt_clr),
    .drop_cnt     (drop_cnt),
    .drop_max     (drop_max)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic [OW-1:0] o, input logic [SW-1:0] s);
    md_rx_valid  = 1'b1;
    md_rx_data   = d;
    md_rx_offset = o;
    md_rx_size   = s;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tests++;
    if ({md_rx_ready, md_rx_err, push_valid, drop_max} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got rdy/err/pv/max=%b want 0000", {md_rx_ready, md_rx_err, push_valid, drop_max});
    end
    tests++;
    if (push_data !== '0 || drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_data: got push_data=%h drop_cnt=%0d want 0/0", push_data, drop_cnt);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_legal_basic();
    logic [PW-1:0] exp;
    exp = {3'd4, 2'd0, 32'hAABBCCDD};
    fifo_full = 1'b0;
    drive(32'hAABBCCDD, 2'd0, 3'd4);
    tick();
    tests++;
    if (push_valid !== 1'b1 || push_data !== exp || md_rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_push: got pv=%b data=%h rdy=%b want 1 %h 0", push_valid, push_data, md_rx_ready, exp);
    end
    tick();
    md_rx_valid = 1'b0;
    tests++;
    if (md_rx_ready !== 1'b1 || md_rx_err !== 1'b0 || push_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_resp: got rdy=%b err=%b pv=%b want 1 0 0", md_rx_ready, md_rx_err, push_valid);
    end
    tick();
    tests++;
    if (md_rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_ready_pulse: got rdy=%b want 0", md_rx_ready);
    end
    tests++;
    if (pushed_q.size() != 1 || pushed_q[0] !== exp) begin
      fails++;
      $display("FAIL basic_fifo: got %0d entries want 1 of %h", pushed_q.size(), exp);
    end
  endtask

  task automatic test_illegal();
    logic [OW-1:0] offs[3];
    logic [SW-1:0] sizes[3];
    offs  = '{2'd1, 2'd3, 2'd0};
    sizes = '{3'd2, 3'd2, 3'd0};
    for (int i = 0; i < 3; i++) begin
      drive(32'h0BAD_0000 + 32'(i), offs[i], sizes[i]);
      tick();
      md_rx_valid = 1'b0;
      tests++;
      if (md_rx_ready !== 1'b1 || md_rx_err !== 1'b1 || push_valid !== 1'b0) begin
        fails++;
        $display("FAIL illegal_resp[%0d]: got rdy=%b err=%b pv=%b want 1 1 0", i, md_rx_ready, md_rx_err, push_valid);
      end
      tick();
      tests++;
      if (md_rx_ready !== 1'b0 || md_rx_err !== 1'b0 || push_valid !== 1'b0) begin
        fails++;
        $display("FAIL illegal_idle[%0d]: got rdy=%b err=%b pv=%b want 0 0 0", i, md_rx_ready, md_rx_err, push_valid);
      end
    end
    tests++;
    if (drop_cnt !== 8'd3 || pushed_q.size() != 1) begin
      fails++;
      $display("FAIL illegal_count: got drop_cnt=%0d pushes=%0d want 3 1", drop_cnt, pushed_q.size());
    end
  endtask

  task automatic test_legal_stall();
    logic [DW-1:0] datas[3];
    logic [OW-1:0] offs[3];
    logic [SW-1:0] sizes[3];
    logic [PW-1:0] exp;
    int            base;
    datas = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    offs  = '{2'd2, 2'd1, 2'd0};
    sizes = '{3'd2, 3'd1, 3'd2};
    base  = pushed_q.size();
    for (int i = 0; i < 3; i++) begin
      exp = {sizes[i], offs[i], datas[i]};
      fifo_full = (i == 0);
      drive(datas[i], offs[i], sizes[i]);
      tick();
      if (i == 0) begin
        for (int c = 0; c < 5; c++) begin
          tests++;
          if (push_valid !== 1'b1 || push_data !== exp || md_rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold[%0d]: got pv=%b data=%h rdy=%b want 1 %h 0", c, push_valid, push_data, md_rx_ready, exp);
          end
          md_rx_data   = ~datas[i];
          md_rx_offset = 2'd3;
          md_rx_size   = 3'd0;
          tick();
        end
        fifo_full = 1'b0;
      end
      tests++;
      if (push_valid !== 1'b1 || push_data !== exp || md_rx_ready !== 1'b0) begin
        fails++;
        $display("FAIL legal_push[%0d]: got pv=%b data=%h rdy=%b want 1 %h 0", i, push_valid, push_data, md_rx_ready, exp);
      end
      tick();
      md_rx_valid = 1'b0;
      tests++;
      if (md_rx_ready !== 1'b1 || md_rx_err !== 1'b0) begin
        fails++;
        $display("FAIL legal_resp[%0d]: got rdy=%b err=%b want 1 0", i, md_rx_ready, md_rx_err);
      end
      tick();
      tests++;
      if (pushed_q.size() != base + i + 1 || pushed_q[base+i] !== exp) begin
        fails++;
        $display("FAIL legal_fifo[%0d]: got %0d entries last=%h want %h", i, pushed_q.size(), pushed_q[$], exp);
      end
    end
    tests++;
    if (drop_cnt !== 8'd3) begin
      fails++;
      $display("FAIL legal_no_drop: got drop_cnt=%0d want 3", drop_cnt);
    end
  endtask

  task automatic test_saturate();
    int max_pulses;
    drop_cnt_clr = 1'b1;
    tick();
    drop_cnt_clr = 1'b0;
    tests++;
    if (drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL clr_alone: got drop_cnt=%0d want 0", drop_cnt);
    end
    max_pulses = 0;
    for (int i = 0; i < 256; i++) begin
      drive(32'(i), 2'd3, 3'd3);
      tick();
      md_rx_valid = 1'b0;
      if (drop_max === 1'b1) max_pulses++;
      tests++;
      if (drop_cnt !== ((i < 255) ? 8'(i + 1) : 8'd255) || drop_max !== (i == 254) || md_rx_err !== 1'b1) begin
        fails++;
        $display("FAIL sat_step[%0d]: got cnt=%0d max=%b err=%b", i, drop_cnt, drop_max, md_rx_err);
      end
      tick();
      if (drop_max === 1'b1) max_pulses++;
    end
    tests++;
    if (max_pulses != 1 || drop_cnt !== 8'd255) begin
      fails++;
      $display("FAIL sat_pulses: got pulses=%0d cnt=%0d want 1 255", max_pulses, drop_cnt);
    end
    drop_cnt_clr = 1'b1;
    drive(32'hDEAD0001, 2'd0, 3'd0);
    tick();
    drop_cnt_clr = 1'b0;
    md_rx_valid  = 1'b0;
    tests++;
    if (drop_cnt !== 8'd1 || drop_max !== 1'b0 || md_rx_err !== 1'b1) begin
      fails++;
      $display("FAIL clr_with_drop: got cnt=%0d max=%b err=%b want 1 0 1", drop_cnt, drop_max, md_rx_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_push();
    int            base;
    int            stray_ready;
    logic [PW-1:0] exp;
    base = pushed_q.size();
    fifo_full = 1'b1;
    drive(32'hCAFEF00D, 2'd0, 3'd4);
    tick();
    tick();
    tests++;
    if (push_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre: got pv=%b want 1", push_valid);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (push_valid !== 1'b0 || push_data !== '0 || md_rx_ready !== 1'b0 || drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rst_mid_async: got pv=%b data=%h rdy=%b cnt=%0d want all 0", push_valid, push_data, md_rx_ready, drop_cnt);
    end
    md_rx_valid = 1'b0;
    fifo_full   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    stray_ready = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (md_rx_ready !== 1'b0 || push_valid !== 1'b0) stray_ready++;
    end
    tests++;
    if (stray_ready != 0 || pushed_q.size() != base) begin
      fails++;
      $display("FAIL rst_mid_abandon: got stray=%0d pushes=%0d want 0 %0d", stray_ready, pushed_q.size(), base);
    end
    exp = {3'd1, 2'd3, 32'h0F0F0F0F};
    drive(32'h0F0F0F0F, 2'd3, 3'd1);
    tick();
    tests++;
    if (push_valid !== 1'b1 || push_data !== exp) begin
      fails++;
      $display("FAIL rst_after_push: got pv=%b data=%h want 1 %h", push_valid, push_data, exp);
    end
    tick();
    md_rx_valid = 1'b0;
    tests++;
    if (md_rx_ready !== 1'b1 || md_rx_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_after_resp: got rdy=%b err=%b want 1 0", md_rx_ready, md_rx_err);
    end
    tick();
    tests++;
    if (pushed_q.size() != base + 1 || pushed_q[$] !== exp) begin
      fails++;
      $display("FAIL rst_after_fifo: got %0d entries want %0d ending %h", pushed_q.size(), base + 1, exp);
    end
  endtask

  initial begin
    test_reset();
    test_legal_basic();
    test_illegal();
    test_legal_stall();
    test_saturate();
    test_reset_mid_push();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
